// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ops registered one cycle after issue; optional iterative
// shift-add MUL (code 0101) built only when ALU_MUL_EN is defined.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic [DATA_W-1:0] data_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              busy_o
);

  logic [DATA_W-1:0]  alu_res;
  logic [SHAMT_W-1:0] shamt;

  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic              valid_q, valid_d;

  assign shamt = data2_i[SHAMT_W-1:0];

  // Add-class codes (ADD/ADDI/LW/SW) share the adder; BEQ reuses subtract so zero_o flags equality.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      4'b0000: alu_res = data1_i & data2_i;
      4'b0001: alu_res = data1_i ^ data2_i;
      4'b0010: alu_res = data1_i << shamt;
      4'b0011, 4'b0110,
      4'b1000, 4'b1001: alu_res = data1_i + data2_i;
      4'b0100, 4'b1010: alu_res = data1_i - data2_i;
      4'b0111: alu_res = DATA_W'($signed(data1_i) >>> shamt);
      4'b1011: alu_res = data1_i | data2_i;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    data_d   = data_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == 4'b0101) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last iteration retires directly so the caller sees the product without an extra bubble.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          data_d  = acc_next;
          zero_d  = (acc_next == '0);
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
`else
  // Without the multiplier, 0101 decodes to zero like any unsupported code.
  always_comb begin
    data_d  = data_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (start_i) begin
      data_d  = alu_res;
      zero_d  = (alu_res == '0);
      valid_d = 1'b1;
    end
  end

  assign busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

endmodule
